// File: rtl/mesh_out_port_arbiter.sv
// mesh_out_port_arbiter
//   Scheduler for one output direction of a mesh router node. Each input
//   FIFO head is routed with dimension-ordered routing. Row-first is used
//   when the mode bit is 1, and column-first when it is 0. The heads that
//   target this output compete in round-robin order. The winner is popped,
//   its Nxt_jump field is overwritten with this node's id, and it is held
//   on out_data_o until the downstream side pops it. In the local (OUT_DIR=4)
//   instance, packets with out-of-mesh destinations are popped and discarded.
//
// Ports
//   clk_i        clock
//   reset_i      asynchronous active-high reset
//   in_pndng_i   [N_IN]          head valid per input FIFO
//   in_data_i    [N_IN*pckg_sz]  head packets, input i at [i*pckg_sz +: pckg_sz]
//   in_pop_o     [N_IN]          one-cycle pop strobe to the winning input
//   out_data_o   [pckg_sz]       registered packet to downstream
//   out_pndng_o                  out_data_o valid
//   out_pop_i                    downstream consumed out_data_o
//   grant_idx_o  [IW]            index of the last winner
//   drop_pulse_o                 one-cycle pulse when an invalid packet is dropped
module mesh_out_port_arbiter #(
    parameter int pckg_sz   = 40,
    parameter int N_IN      = 4,
    parameter int OUT_DIR   = 0,
    parameter int id_row    = 1,
    parameter int id_column = 1,
    parameter int ROWS      = 4,
    parameter int COLUMS    = 4,
    localparam int IW       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [N_IN-1:0]           in_pndng_i,
    input  logic [N_IN*pckg_sz-1:0]   in_data_i,
    output logic [N_IN-1:0]           in_pop_o,
    output logic [pckg_sz-1:0]        out_data_o,
    output logic                      out_pndng_o,
    input  logic                      out_pop_i,
    output logic [IW-1:0]             grant_idx_o,
    output logic                      drop_pulse_o
);

    localparam logic [2:0] DIR_N   = 3'd0;
    localparam logic [2:0] DIR_S   = 3'd1;
    localparam logic [2:0] DIR_E   = 3'd2;
    localparam logic [2:0] DIR_W   = 3'd3;
    localparam logic [2:0] DIR_L   = 3'd4;
    localparam logic [2:0] DIR_OUT = 3'(OUT_DIR);
    localparam logic       IS_LOCAL = (OUT_DIR == 4);
    localparam logic [3:0] ROW_ID  = 4'(id_row);
    localparam logic [3:0] COL_ID  = 4'(id_column);
    localparam logic [4:0] ROW_MAX = 5'(ROWS + 1);
    localparam logic [4:0] COL_MAX = 5'(COLUMS + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state_q;
    logic [IW-1:0]        rr_q;
    logic [IW-1:0]        grant_q;
    logic [pckg_sz-1:0]   out_data_q;
    logic                 out_pndng_q;

    logic [N_IN-1:0]      req;
    logic [N_IN-1:0]      bad;
    logic                 found_d;
    logic [IW-1:0]        win_d;
    logic [IW-1:0]        rr_d;
    logic                 drop_d;
    logic                 pop_en;
    logic [pckg_sz-1:0]   head_win;
    logic [pckg_sz-1:0]   out_data_d;

    // Per-input route computation and request qualification
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_route
            logic [3:0] d_row;
            logic [3:0] d_col;
            logic       d_mode;
            logic [2:0] dir;

            assign d_row  = in_data_i[gi*pckg_sz + pckg_sz-9  -: 4];
            assign d_col  = in_data_i[gi*pckg_sz + pckg_sz-13 -: 4];
            assign d_mode = in_data_i[gi*pckg_sz + pckg_sz-17];

            always_comb begin
                dir = DIR_L;
                if (d_mode) begin
                    if      (d_row < ROW_ID) dir = DIR_N;
                    else if (d_row > ROW_ID) dir = DIR_S;
                    else if (d_col < COL_ID) dir = DIR_W;
                    else if (d_col > COL_ID) dir = DIR_E;
                end else begin
                    if      (d_col < COL_ID) dir = DIR_W;
                    else if (d_col > COL_ID) dir = DIR_E;
                    else if (d_row < ROW_ID) dir = DIR_N;
                    else if (d_row > ROW_ID) dir = DIR_S;
                end
            end

            // Out-of-mesh destinations are only ever claimed by the local port,
            // which discards them so they cannot block the input FIFO.
            assign bad[gi] = ({1'b0, d_row} > ROW_MAX) || ({1'b0, d_col} > COL_MAX);
            assign req[gi] = in_pndng_i[gi] && (bad[gi] ? IS_LOCAL : (dir == DIR_OUT));

            assign in_pop_o[gi] = pop_en && (win_d == IW'(gi));
        end
    endgenerate

    // Round-robin pick: first request at or after rr_q, wrapping
    always_comb begin
        int idx;
        idx     = 0;
        found_d = 1'b0;
        win_d   = '0;
        for (int k = 0; k < N_IN; k++) begin
            idx = (int'(rr_q) + k) % N_IN;
            if (!found_d && req[idx]) begin
                found_d = 1'b1;
                win_d   = IW'(idx);
            end
        end
    end

    always_comb begin
        rr_d     = (int'(win_d) == N_IN - 1) ? '0 : win_d + IW'(1);
        drop_d   = IS_LOCAL && bad[win_d];
        head_win = in_data_i[win_d*pckg_sz +: pckg_sz];
        out_data_d = head_win;
        out_data_d[pckg_sz-1 -: 8] = {ROW_ID, COL_ID};
    end

    // The pop strobe is combinational so the input FIFO pops in the grant cycle.
    // It is masked during reset so nothing is consumed while the FSM is being
    // cleared.
    assign pop_en       = (state_q == IDLE) && found_d && !reset_i;
    assign drop_pulse_o = pop_en && drop_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            out_data_q  <= '0;
            out_pndng_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grant_q <= win_d;
                        rr_q    <= rr_d;
                        if (!drop_d) begin
                            out_data_q  <= out_data_d;
                            out_pndng_q <= 1'b1;
                            state_q     <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (out_pop_i) begin
                        out_pndng_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data_o  = out_data_q;
    assign out_pndng_o = out_pndng_q;
    assign grant_idx_o = grant_q;

endmodule

// File: tb/tb_mesh_out_port_arbiter.sv
// Bench for mesh_out_port_arbiter: five instances (N,S,E,W,local) of node (1,1)
// share the same input FIFO heads, exactly as inside a router node. The FIFOs
// and the expected schedule are modelled as queues plus per-port busy/pointer
// state, derived from the routing and round-robin rules.
module tb_mesh_out_port_arbiter;

    localparam int PW = 40;
    localparam int NI = 4;
    localparam int ND = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI-1:0]     pndng;
    logic [NI*PW-1:0]  data;
    logic [ND-1:0]     opop;
    logic [NI-1:0]     ipop  [ND];
    logic [PW-1:0]     odata [ND];
    logic              opnd  [ND];
    logic [1:0]        gidx  [ND];
    logic              drop  [ND];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_dut
            mesh_out_port_arbiter #(
                .pckg_sz(PW), .N_IN(NI), .OUT_DIR(gi), .id_row(1), .id_column(1),
                .ROWS(4), .COLUMS(4)
            ) u_dut (
                .clk_i(clk), .reset_i(rst), .in_pndng_i(pndng), .in_data_i(data),
                .in_pop_o(ipop[gi]), .out_data_o(odata[gi]), .out_pndng_o(opnd[gi]),
                .out_pop_i(opop[gi]), .grant_idx_o(gidx[gi]), .drop_pulse_o(drop[gi])
            );
        end
    endgenerate

    // Reference model state
    logic [PW-1:0] fifo [NI][$];
    bit            m_busy  [ND];
    int            m_ptr   [ND];
    int            m_grant [ND];
    logic [PW-1:0] m_data  [ND];
    int            pop_pct;
    int            n_chk = 0;
    int            n_fail = 0;

    function automatic logic [PW-1:0] mk(int r, int c, bit m);
        logic [7:0]  nj;
        logic [22:0] pl;
        nj = 8'($urandom);
        pl = 23'($urandom);
        return {nj, 4'(r), 4'(c), m, pl};
    endfunction

    function automatic bit is_bad(logic [PW-1:0] p);
        return (int'(p[31:28]) > 5) || (int'(p[27:24]) > 5);
    endfunction

    // Output port a head should leave through, as seen from node (1,1)
    function automatic int target(logic [PW-1:0] p);
        int dr, dc;
        bit vertical;
        if (is_bad(p)) return 4;
        dr = int'(p[31:28]) - 1;
        dc = int'(p[27:24]) - 1;
        if (dr == 0 && dc == 0) return 4;
        vertical = p[23] ? (dr != 0) : (dc == 0);
        if (vertical) return (dr < 0) ? 0 : 1;
        return (dc < 0) ? 3 : 2;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_busy[d] = 1'b0; m_ptr[d] = 0; m_grant[d] = 0; m_data[d] = '0;
        end
    endtask

    // One clock cycle: drive heads, check all instances, advance the model
    task automatic step();
        int            win [ND];
        logic [NI-1:0] ep;
        logic [PW-1:0] p;
        for (int i = 0; i < NI; i++) begin
            pndng[i] = (fifo[i].size() > 0);
            data[i*PW +: PW] = (fifo[i].size() > 0) ? fifo[i][0] : '0;
        end
        for (int d = 0; d < ND; d++) opop[d] = ($urandom_range(0, 99) < pop_pct);
        #1;
        for (int d = 0; d < ND; d++) begin
            win[d] = -1;
            if (!m_busy[d])
                for (int k = 0; k < NI; k++) begin
                    int i;
                    i = (m_ptr[d] + k) % NI;
                    if (win[d] < 0 && fifo[i].size() > 0 && target(fifo[i][0]) == d) win[d] = i;
                end
            ep = (win[d] >= 0) ? 4'(1 << win[d]) : 4'd0;
            check($sformatf("in_pop_d%0d", d), 64'(ipop[d]), 64'(ep));
            check($sformatf("drop_d%0d", d), 64'(drop[d]),
                  64'((win[d] >= 0) && is_bad(fifo[win[d]][0])));
            check($sformatf("out_pndng_d%0d", d), 64'(opnd[d]), 64'(m_busy[d]));
            check($sformatf("out_data_d%0d", d), 64'(odata[d]), 64'(m_data[d]));
            check($sformatf("grant_d%0d", d), 64'(gidx[d]), 64'(m_grant[d]));
        end
        for (int d = 0; d < ND; d++) begin
            if (m_busy[d]) begin
                if (opop[d]) m_busy[d] = 1'b0;
            end else if (win[d] >= 0) begin
                p = fifo[win[d]].pop_front();
                m_grant[d] = win[d];
                m_ptr[d]   = (win[d] + 1) % NI;
                if (is_bad(p)) begin
                    $display("t=%0t dir%0d drop  in%0d pkt=%h", $time, d, win[d], p);
                end else begin
                    m_busy[d] = 1'b1;
                    m_data[d] = {8'h11, p[31:0]};
                    $display("t=%0t dir%0d grant in%0d pkt=%h", $time, d, win[d], p);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run(int n);
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        rst = 1'b1; pndng = '0; data = '0; opop = '0; pop_pct = 100;
        model_reset();
        #2;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst_pndng_d%0d", d), 64'(opnd[d]), 64'd0);
            check($sformatf("rst_data_d%0d", d), 64'(odata[d]), 64'd0);
            check($sformatf("rst_pop_d%0d", d), 64'(ipop[d]), 64'd0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Single packet south, Nxt_jump rewrite
        fifo[0].push_back(mk(3, 1, 1));
        run(4);

        // All four inputs target S: rotation 0,1,2,3,0,...
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NI; i++) fifo[i].push_back(mk(3, $urandom_range(0, 5), 1));
        run(20);

        // Routing mode selects the port
        fifo[0].push_back(mk(1, 3, 1));
        fifo[1].push_back(mk(3, 3, 0));
        fifo[2].push_back(mk(3, 3, 1));
        run(8);

        // Downstream stall for 20+ cycles, then release
        pop_pct = 0;
        fifo[0].push_back(mk(2, 1, 1));
        fifo[1].push_back(mk(3, 1, 1));
        run(22);
        pop_pct = 100;
        run(6);

        // Local port: invalid destination dropped, own address forwarded
        fifo[3].push_back(mk(7, 2, 1));
        fifo[3].push_back(mk(1, 1, 0));
        fifo[2].push_back(mk(2, 9, 0));
        run(8);

        // Random traffic with random back-pressure
        pop_pct = 60;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) < 50) begin
                int i;
                i = $urandom_range(0, NI - 1);
                if (fifo[i].size() < 4)
                    fifo[i].push_back(mk($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom)));
            end
            step();
        end

        // Async reset in the middle of SEND
        for (int i = 0; i < NI; i++) fifo[i].delete();
        run(6);
        pop_pct = 0;
        fifo[0].push_back(mk(3, 1, 1));
        run(3);
        check("send_before_rst", 64'(opnd[1]), 64'd1);
        #3 rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("async_rst_pndng_d%0d", d), 64'(opnd[d]), 64'd0);
            check($sformatf("async_rst_grant_d%0d", d), 64'(gidx[d]), 64'd0);
        end
        for (int i = 0; i < NI; i++) fifo[i].delete();
        pndng = '0;
        model_reset();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        pop_pct = 100;
        fifo[3].push_back(mk(4, 1, 1));
        fifo[2].push_back(mk(5, 1, 1));
        step();
        check("post_rst_first_win", 64'(gidx[1]), 64'd2);
        run(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mesh_out_port_arbiter.md
Name: mesh_out_port_arbiter

Overview:
- Per-output-port scheduler inside a mesh router node (mesh_gnrtr fabric, ROWS x COLUMS).
- Watches the show-ahead heads of the node's input FIFOs and computes each head's next-hop direction with dimension-ordered routing (mode bit selects row-first or column-first).
- Round-robin arbitrates among the inputs that target this block's output direction, pops the winner, rewrites the Nxt_jump field and presents the packet to the downstream FIFO with a pndng/pop handshake.
- Node builds five instances, one per OUT_DIR.

Parameters:
- pckg_sz, 40: packet width in bits.
- N_IN, 4: number of input FIFOs arbitrated.
- OUT_DIR, 0: direction served. 0=N, 1=S, 2=E, 3=W, 4=local terminal.
- id_row, 1: row of this node (4-bit range).
- id_column, 1: column of this node (4-bit range).
- ROWS, 4: mesh rows. Valid destination rows are 0..ROWS+1.
- COLUMS, 4: mesh columns. Valid destination columns are 0..COLUMS+1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_pndng  in  N_IN  head valid per input FIFO
- in_data  in  N_IN*pckg_sz  head packets, input i at [i*pckg_sz +: pckg_sz]
- in_pop  out  N_IN  one-cycle pop strobe per input
- out_data  out  pckg_sz  registered packet to downstream
- out_pndng  out  1  out_data valid
- out_pop  in  1  downstream consumed out_data
- grant_idx  out  $clog2(N_IN)  index of last winner
- drop_pulse  out  1  one-cycle pulse when an invalid-destination packet is discarded (OUT_DIR=4 only, else tied 0)

Behaviour:
- Packet fields:
  - [pckg_sz-1 -: 8] Nxt_jump
  - [pckg_sz-9 -: 4] dest row
  - [pckg_sz-13 -: 4] dest col
  - [pckg_sz-17] mode
  - [pckg_sz-18:0] payload
- Route compute (combinational, per input with in_pndng=1):
  - dest == (id_row, id_column): local (4).
  - mode=1, row-first: dest row < id_row gives N; > gives S; equal resolves by column (< W, > E).
  - mode=0, column-first: column comparison first, then row.
  - req[i] = in_pndng[i] and dir==OUT_DIR.
- Invalid destination (row>ROWS+1 or col>COLUMS+1):
  - Counts as a request only for OUT_DIR=4.
  - When granted, the packet is popped, not forwarded, and drop_pulse is asserted for one cycle.
- FSM has two states: IDLE and SEND.
- IDLE:
  - If any req: winner = first req at or after rr_ptr, wrapping modulo N_IN.
  - Same cycle: in_pop[winner]=1, out_data <= head with Nxt_jump replaced by {id_row[3:0], id_column[3:0]}, grant_idx <= winner, rr_ptr <= (winner+1) mod N_IN, next state SEND.
  - For a drop, stay in IDLE instead.
- SEND:
  - out_pndng=1 and out_data held stable.
  - On out_pop, next state IDLE and out_pndng=0 next cycle.
  - No new grant while in SEND. Max throughput is 1 packet per 2 cycles.
- Latency: request visible at cycle n gives in_pop at n and out_pndng at n+1.
- At most one in_pop bit is high per cycle. in_pop is never asserted when in_pndng=0.
- out_pop while out_pndng=0 is ignored.
- Downstream stall: SEND is held indefinitely. Inputs are not popped and rr_ptr is frozen.
- Simultaneous requests: exactly one winner. A continuously requesting input waits at most N_IN-1 grants.
- Head changing without a pop does not occur. The block does not check for it.
- Reset (async, any state):
  - State=IDLE, rr_ptr=0, grant_idx=0.
  - out_pndng=0, out_data=0, in_pop=0, drop_pulse=0.
  - A packet held in SEND is lost.
  - First grant after reset deassertion is the lowest-index requester.

Test Plan:
1. OUT_DIR=1, node (1,1). in0 head dest (3,1), mode=1 -> in_pop[0] same cycle; next cycle out_pndng=1, out_data Nxt_jump=8'h11, remaining fields unchanged.
2. All 4 inputs target S continuously, out_pop asserted every SEND cycle -> grant order 0,1,2,3,0; in_pop pulses every 2nd cycle.
3. Dest (1,3): with mode=1 only the OUT_DIR=2 (E) instance requests. Dest (3,3): with mode=0 the E instance requests, with mode=1 the S instance requests.
4. out_pop held 0 for 20 cycles after grant -> out_data stable, out_pndng=1, no in_pop; pop releases, next grant at the following cycle.
5. OUT_DIR=4, dest (7,2) with ROWS=4 -> in_pop and drop_pulse for 1 cycle; out_pndng stays 0. Dest (1,1) -> forwarded locally.
6. Reset asserted mid-SEND (async, between edges) -> out_pndng=0 immediately; after release, requests on inputs 2 and 3 -> input 2 wins first.
